// File: rtl/imem_refill_responder.sv
// imem_refill_responder: memory-side responder streaming one instruction block per cache refill request.
// Ports:
//   clk, reset (async, active-low)
//   miss, fetchaddr          - refill request from the instruction cache
//   ifetch, iready           - one data word per iready strobe
//   busy                     - request in progress
//   range_err                - sticky flag: a beat addressed a word beyond the backing array
//   prog_we, prog_addr, prog_data - preload write port into the backing array
module imem_refill_responder #(
    parameter int WORDSPERBLOCK = 4,
    parameter int MEMDEPTH      = 1024,
    parameter int LATENCY       = 2,
    parameter int BEATGAP       = 0
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        miss,
    input  logic [31:0]                 fetchaddr,
    output logic [31:0]                 ifetch,
    output logic                        iready,
    output logic                        busy,
    output logic                        range_err,
    input  logic                        prog_we,
    input  logic [$clog2(MEMDEPTH)-1:0] prog_addr,
    input  logic [31:0]                 prog_data
);
    localparam int AW = $clog2(MEMDEPTH);
    localparam logic [31:0] NOP = 32'h0000_0013;
    typedef enum logic [2:0] {IDLE, WAIT, BEAT, GAP, RECOVER} state_t;
    state_t state, state_nx;
    logic [29:0] base;
    logic [4:0] beat;
    logic [3:0] cnt;
    logic [29:0] idx;
    logic oob;
    logic [31:0] mem [MEMDEPTH];
    logic [31:0] ifetch_d;
    logic iready_d, busy_d, range_err_d;
    assign idx = base + 30'(beat);
    assign oob = 32'(idx) >= 32'(MEMDEPTH);
    // Outputs are registered from the current state, so everything visible lags the state by one cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            base      <= '0;
            beat      <= '0;
            cnt       <= '0;
            ifetch    <= '0;
            iready    <= 1'b0;
            busy      <= 1'b0;
            range_err <= 1'b0;
        end else begin
            state     <= state_nx;
            base      <= (state == IDLE && miss) ? (30'(fetchaddr >> 2) & ~30'(WORDSPERBLOCK - 1)) : base;
            beat      <= (state == IDLE) ? '0 : (state == BEAT) ? beat + 5'd1 : beat;
            cnt       <= (state_nx != state) ? '0 : cnt + 4'd1;
            ifetch    <= ifetch_d;
            iready    <= iready_d;
            busy      <= busy_d;
            range_err <= range_err_d;
        end
    end
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = !miss ? IDLE : (LATENCY > 0) ? WAIT : BEAT;
            WAIT:    state_nx = !miss ? IDLE : (cnt == 4'(LATENCY - 1)) ? BEAT : WAIT;
            BEAT:    state_nx = (beat == 5'(WORDSPERBLOCK - 1)) ? RECOVER : (BEATGAP > 0) ? GAP : BEAT;
            GAP:     state_nx = !miss ? IDLE : (cnt == 4'(BEATGAP - 1)) ? BEAT : GAP;
            default: state_nx = IDLE;
        endcase
    end
    // The array read and a same-edge preload write land together, so a colliding beat sees the old word.
    always_comb begin
        iready_d    = state == BEAT;
        busy_d      = state != IDLE;
        ifetch_d    = !iready_d ? ifetch : oob ? NOP : mem[idx[AW-1:0]];
        range_err_d = range_err | (iready_d & oob);
    end
    always_ff @(posedge clk) begin
        if (prog_we) mem[prog_addr] <= prog_data;
    end
endmodule
